alu_rs_param: RTL and testbench

- Parametrised successor of the ALU reservation station in the out-of-order RISC-V core; sits between dispatch and the ALU.
- Holds up to RS_DEPTH renamed ALU ops, wakes operands from N_CDB broadcast buses, including same-cycle capture at dispatch.
- Issues the oldest ready entry through a registered valid/ready port that tolerates ALU back-pressure.
- Flushes on rst or clear (branch mispredict).

---
 rtl/alu_rs_param_pkg.sv | 15 +
 rtl/alu_rs_param_if.sv | 63 ++++++
 rtl/alu_rs_param_rs_age_select.sv | 30 +++
 rtl/alu_rs_param.sv | 173 +++++++++++++++++
 tb/tb_alu_rs_param.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_param_pkg.sv
// Shared definitions for the ALU reservation station and its sibling stations.
package alu_rs_param_pkg;

    // Default widths used across the out-of-order core.
    localparam int TAG_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 6;
    localparam int ADDR_W_DEF = 32;

    // Core-wide flag and fill constants.
    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam int   NULL    = 0;

endpackage

// File: rtl/alu_rs_param_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// The master side is the dispatch/CDB/ALU environment; the slave side is the station.
interface alu_rs_param_if
    import alu_rs_param_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int N_CDB    = 4,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
);
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    logic                    full;
    logic [CNT_W-1:0]        count;

    logic                    disp_valid;
    logic [OP_W-1:0]         disp_op;
    logic [DATA_W-1:0]       disp_imm;
    logic [ADDR_W-1:0]       disp_pc;
    logic                    disp_r1_valid;
    logic                    disp_r2_valid;
    logic [DATA_W-1:0]       disp_r1_data;
    logic [DATA_W-1:0]       disp_r2_data;
    logic [TAG_W-1:0]        disp_r1_tag;
    logic [TAG_W-1:0]        disp_r2_tag;
    logic [TAG_W-1:0]        disp_dest_tag;

    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data;

    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [DATA_W-1:0]       iss_r1;
    logic [DATA_W-1:0]       iss_r2;
    logic [DATA_W-1:0]       iss_imm;
    logic [ADDR_W-1:0]       iss_pc;
    logic [TAG_W-1:0]        iss_dest;

    modport master (
        input  full, count,
        output disp_valid, disp_op, disp_imm, disp_pc,
        output disp_r1_valid, disp_r2_valid, disp_r1_data, disp_r2_data,
        output disp_r1_tag, disp_r2_tag, disp_dest_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  iss_valid, iss_op, iss_r1, iss_r2, iss_imm, iss_pc, iss_dest,
        output iss_ready
    );

    modport slave (
        output full, count,
        input  disp_valid, disp_op, disp_imm, disp_pc,
        input  disp_r1_valid, disp_r2_valid, disp_r1_data, disp_r2_data,
        input  disp_r1_tag, disp_r2_tag, disp_dest_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output iss_valid, iss_op, iss_r1, iss_r2, iss_imm, iss_pc, iss_dest,
        input  iss_ready
    );

endinterface

// File: rtl/alu_rs_param_rs_age_select.sv
// Oldest-ready selector: picks the ready entry that no other ready entry is older than.
// older[i][j] = 1 means entry i is older than entry j.
module rs_age_select
    import alu_rs_param_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [DEPTH-1:0] older [DEPTH],
    output logic [DEPTH-1:0] pick,
    output logic             any_ready
);

    // An entry wins when it is ready and no ready entry is older than it.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
        pick = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pick[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i]) begin
                    pick[i] = INVALID;
                end
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/alu_rs_param.sv
// ALU reservation station: holds renamed ops, wakes operands from the CDB
// (including capture at dispatch) and issues the oldest ready op through a
// registered valid/ready slot that tolerates ALU back-pressure.
module alu_rs_param
    import alu_rs_param_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int N_CDB    = 4,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clear,
    alu_rs_param_if.slave bus
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Returns {hit, data}; on several matching channels the lowest index wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        cdb_valid,
        input logic [N_CDB*TAG_W-1:0]  cdb_tag,
        input logic [N_CDB*DATA_W-1:0] cdb_data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                res = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Entry control state.
    logic [RS_DEPTH-1:0] valid;
    logic [RS_DEPTH-1:0] older [RS_DEPTH];

    // Entry payload.
    logic [OP_W-1:0]     op       [RS_DEPTH];
    logic [DATA_W-1:0]   imm      [RS_DEPTH];
    logic [ADDR_W-1:0]   pc       [RS_DEPTH];
    logic [TAG_W-1:0]    dest_tag [RS_DEPTH];
    logic [RS_DEPTH-1:0] r1_ok;
    logic [RS_DEPTH-1:0] r2_ok;
    logic [DATA_W-1:0]   r1_data  [RS_DEPTH];
    logic [DATA_W-1:0]   r2_data  [RS_DEPTH];
    logic [TAG_W-1:0]    r1_tag   [RS_DEPTH];
    logic [TAG_W-1:0]    r2_tag   [RS_DEPTH];

    // Wakeup and selection.
    logic [RS_DEPTH-1:0] wake1;
    logic [RS_DEPTH-1:0] wake2;
    logic [DATA_W-1:0]   wake1_data [RS_DEPTH];
    logic [DATA_W-1:0]   wake2_data [RS_DEPTH];
    logic                disp1_hit;
    logic                disp2_hit;
    logic [DATA_W-1:0]   disp1_data;
    logic [DATA_W-1:0]   disp2_data;
    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] pick;
    logic                any_ready;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic                disp_fire;
    logic                load;

    // Full is derived from the current valid bits, so a slot freed this cycle is not reusable yet.
    assign bus.full  = &valid;
    assign disp_fire = bus.disp_valid && !bus.full;
    assign ready     = valid & r1_ok & r2_ok;
    assign load      = (!bus.iss_valid || bus.iss_ready) && any_ready;

    rs_age_select #(.DEPTH(RS_DEPTH)) u_age_select (
        .ready     (ready),
        .older     (older),
        .pick      (pick),
        .any_ready (any_ready)
    );

    // Compare every entry's tags and the dispatch tags against all CDB channels.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            {wake1[i], wake1_data[i]} = cdb_lookup(r1_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            {wake2[i], wake2_data[i]} = cdb_lookup(r2_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        {disp1_hit, disp1_data} = cdb_lookup(bus.disp_r1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        {disp2_hit, disp2_data} = cdb_lookup(bus.disp_r2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Encode the lowest free slot and the one-hot pick as indices.
    always_comb begin
        free_idx = '0;
        pick_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    // Valid bits, age matrix, occupancy and issue slot; rst/clear win over everything.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read here sees pre-edge values.
        if (rst || clear) begin
            valid         <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
            bus.count     <= CNT_W'(NULL);
            bus.iss_valid <= INVALID;
            bus.iss_op    <= '0;
            bus.iss_r1    <= '0;
            bus.iss_r2    <= '0;
            bus.iss_imm   <= '0;
            bus.iss_pc    <= '0;
            bus.iss_dest  <= '0;
        end else if (rdy) begin
            if (load) begin
                valid[pick_idx] <= INVALID;
                bus.iss_valid   <= VALID;
                bus.iss_op      <= op[pick_idx];
                bus.iss_r1      <= r1_data[pick_idx];
                bus.iss_r2      <= r2_data[pick_idx];
                bus.iss_imm     <= imm[pick_idx];
                bus.iss_pc      <= pc[pick_idx];
                bus.iss_dest    <= dest_tag[pick_idx];
            end else if (bus.iss_ready) begin
                bus.iss_valid <= INVALID;
            end
            if (disp_fire) begin
                valid[free_idx] <= VALID;
                for (int x = 0; x < RS_DEPTH; x++) older[x][free_idx] <= valid[x];
                older[free_idx] <= '0;
            end
            bus.count <= bus.count + CNT_W'(disp_fire) - CNT_W'(load);
        end
    end

    // Operand wakeup and dispatch writes into the payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset on purpose; nothing reads it unless the entry's valid bit is set.
        if (rdy) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (valid[i] && !r1_ok[i] && wake1[i]) begin
                    r1_ok[i]   <= VALID;
                    r1_data[i] <= wake1_data[i];
                end
                if (valid[i] && !r2_ok[i] && wake2[i]) begin
                    r2_ok[i]   <= VALID;
                    r2_data[i] <= wake2_data[i];
                end
            end
            if (disp_fire) begin
                op[free_idx]       <= bus.disp_op;
                imm[free_idx]      <= bus.disp_imm;
                pc[free_idx]       <= bus.disp_pc;
                dest_tag[free_idx] <= bus.disp_dest_tag;
                r1_tag[free_idx]   <= bus.disp_r1_tag;
                r2_tag[free_idx]   <= bus.disp_r2_tag;
                r1_ok[free_idx]    <= bus.disp_r1_valid || disp1_hit;
                r2_ok[free_idx]    <= bus.disp_r2_valid || disp2_hit;
                r1_data[free_idx]  <= bus.disp_r1_valid ? bus.disp_r1_data : disp1_data;
                r2_data[free_idx]  <= bus.disp_r2_valid ? bus.disp_r2_data : disp2_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_param.sv
// Self-checking bench for alu_rs_param: directed scenarios plus a randomized
// run against an age-by-sequence-number reference model.
module tb_alu_rs_param;
    import alu_rs_param_pkg::*;

    localparam int D  = 8;
    localparam int NC = 4;
    localparam int TW = 4;
    localparam int DW = 32;
    localparam int OW = 6;
    localparam int AW = 32;
    localparam int CW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    int vectors     = 0;
    int miscompares = 0;

    alu_rs_param_if #(.RS_DEPTH(D), .N_CDB(NC), .TAG_W(TW), .DATA_W(DW), .OP_W(OW), .ADDR_W(AW)) bus ();

    alu_rs_param #(.RS_DEPTH(D), .N_CDB(NC), .TAG_W(TW), .DATA_W(DW), .OP_W(OW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit            m_valid [D];
    int            m_seq   [D];
    bit            m_ok1   [D];
    bit            m_ok2   [D];
    logic [OW-1:0] m_op    [D];
    logic [DW-1:0] m_r1    [D];
    logic [DW-1:0] m_r2    [D];
    logic [DW-1:0] m_imm   [D];
    logic [AW-1:0] m_pc    [D];
    logic [TW-1:0] m_t1    [D];
    logic [TW-1:0] m_t2    [D];
    logic [TW-1:0] m_dest  [D];
    int            m_next_seq;
    bit            m_iss_valid;
    logic [OW+3*DW+AW+TW-1:0] m_iss_fields;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic bit cdb_find(input logic [TW-1:0] tag, output logic [DW-1:0] data);
        for (int k = 0; k < NC; k++) begin
            if (bus.cdb_valid[k] && bus.cdb_tag[k*TW +: TW] == tag) begin
                data = bus.cdb_data[k*DW +: DW];
                return 1'b1;
            end
        end
        data = '0;
        return 1'b0;
    endfunction

    task automatic model_step();
        int free;
        int pick;
        logic [DW-1:0] d;
        if (rst || clear) begin
            for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
            m_iss_valid  = 1'b0;
            m_iss_fields = '0;
            return;
        end
        if (!rdy) return;
        free = -1;
        if (bus.disp_valid) begin
            for (int i = 0; i < D; i++) if (!m_valid[i] && free < 0) free = i;
        end
        pick = -1;
        if (!m_iss_valid || bus.iss_ready) begin
            for (int i = 0; i < D; i++)
                if (m_valid[i] && m_ok1[i] && m_ok2[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
        end
        if (pick >= 0) begin
            m_iss_valid   = 1'b1;
            m_iss_fields  = {m_op[pick], m_r1[pick], m_r2[pick], m_imm[pick], m_pc[pick], m_dest[pick]};
            m_valid[pick] = 1'b0;
        end else if (bus.iss_ready) begin
            m_iss_valid = 1'b0;
        end
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && !m_ok1[i] && cdb_find(m_t1[i], d)) begin m_ok1[i] = 1'b1; m_r1[i] = d; end
            if (m_valid[i] && !m_ok2[i] && cdb_find(m_t2[i], d)) begin m_ok2[i] = 1'b1; m_r2[i] = d; end
        end
        if (free >= 0) begin
            m_valid[free] = 1'b1;
            m_seq[free]   = m_next_seq++;
            m_op[free]    = bus.disp_op;
            m_imm[free]   = bus.disp_imm;
            m_pc[free]    = bus.disp_pc;
            m_dest[free]  = bus.disp_dest_tag;
            m_t1[free]    = bus.disp_r1_tag;
            m_t2[free]    = bus.disp_r2_tag;
            m_ok1[free]   = bus.disp_r1_valid;
            m_ok2[free]   = bus.disp_r2_valid;
            m_r1[free]    = bus.disp_r1_data;
            m_r2[free]    = bus.disp_r2_data;
            if (!m_ok1[free] && cdb_find(m_t1[free], d)) begin m_ok1[free] = 1'b1; m_r1[free] = d; end
            if (!m_ok2[free] && cdb_find(m_t2[free], d)) begin m_ok2[free] = 1'b1; m_r2[free] = d; end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clear = 1'b0; rst = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = '0;
        bus.iss_ready  = 1'b1;
    endtask

    task automatic set_disp(input logic [OW-1:0] op,
                            input logic r1v, input logic [DW-1:0] r1d, input logic [TW-1:0] r1t,
                            input logic r2v, input logic [DW-1:0] r2d, input logic [TW-1:0] r2t,
                            input logic [TW-1:0] dest);
        bus.disp_valid    = 1'b1;
        bus.disp_op       = op;
        bus.disp_r1_valid = r1v; bus.disp_r1_data = r1d; bus.disp_r1_tag = r1t;
        bus.disp_r2_valid = r2v; bus.disp_r2_data = r2d; bus.disp_r2_tag = r2t;
        bus.disp_dest_tag = dest;
        bus.disp_imm      = $urandom;
        bus.disp_pc       = $urandom;
    endtask

    task automatic set_cdb(input int k, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.cdb_valid[k]           = 1'b1;
        bus.cdb_tag[k*TW +: TW]    = tag;
        bus.cdb_data[k*DW +: DW]   = data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        bus.cdb_tag = '0; bus.cdb_data = '0;
        set_disp('0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        bus.disp_valid = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++; if (bus.count !== CW'(0)) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b want 0", bus.full); end
        vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL reset_iss_valid: got %0b want 0", bus.iss_valid); end
        vectors++;
        if ({bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_imm, bus.iss_pc, bus.iss_dest} !== '0) begin
            miscompares++; $display("FAIL reset_iss_fields: got %h want 0", {bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_dest});
        end
    endtask

    task automatic test_basic();
        idle_inputs();
        set_disp(6'h01, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        step();
        bus.disp_valid = 1'b0;
        vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_issue: got %0b want 0", bus.iss_valid); end
        vectors++; if (bus.count !== CW'(1)) begin miscompares++; $display("FAIL basic_count1: got %0d want 1", bus.count); end
        step();
        vectors++; if (bus.iss_valid !== 1'b1) begin miscompares++; $display("FAIL basic_iss_valid: got %0b want 1", bus.iss_valid); end
        vectors++;
        if ({bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_dest} !== {6'h01, 32'd5, 32'd7, 4'd3}) begin
            miscompares++; $display("FAIL basic_fields: got op=%h r1=%0d r2=%0d dest=%0d want 1/5/7/3", bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_dest);
        end
        vectors++; if (bus.count !== CW'(0)) begin miscompares++; $display("FAIL basic_count0: got %0d want 0", bus.count); end
        step();
        vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: got %0b want 0", bus.iss_valid); end
    endtask

    task automatic test_full();
        idle_inputs();
        for (int i = 0; i < D; i++) begin
            set_disp(6'h02, 1'b0, '0, 4'd9, 1'b1, DW'(i), 4'd0, TW'(i));
            step();
        end
        vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %0b want 1", bus.full); end
        vectors++; if (bus.count !== CW'(D)) begin miscompares++; $display("FAIL full_count: got %0d want %0d", bus.count, D); end
        set_disp(6'h02, 1'b1, 32'd1, 4'd0, 1'b1, 32'd99, 4'd0, 4'd15);
        step();
        bus.disp_valid = 1'b0;
        vectors++; if (bus.count !== CW'(D)) begin miscompares++; $display("FAIL full_ignored: got %0d want %0d", bus.count, D); end
        set_cdb(2, 4'd9, 32'hABCD);
        step();
        bus.cdb_valid = '0;
        vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL full_wake_latency: got %0b want 0", bus.iss_valid); end
        // A dispatch on the pick edge must be refused: the slot being freed is still valid.
        set_disp(6'h02, 1'b1, 32'd1, 4'd0, 1'b1, 32'd77, 4'd0, 4'd14);
        for (int i = 0; i < D; i++) begin
            step();
            if (i == 0) begin
                bus.disp_valid = 1'b0;
                vectors++; if (bus.count !== CW'(D - 1)) begin miscompares++; $display("FAIL full_same_cycle_reuse: got %0d want %0d", bus.count, D - 1); end
            end
            vectors++;
            if ({bus.iss_valid, bus.iss_r1, bus.iss_r2} !== {1'b1, 32'hABCD, DW'(i)}) begin
                miscompares++; $display("FAIL full_order_%0d: got v=%0b r1=%h r2=%0d want 1/abcd/%0d", i, bus.iss_valid, bus.iss_r1, bus.iss_r2, i);
            end
        end
        step();
        vectors++; if (bus.iss_valid !== 1'b0 || bus.count !== CW'(0)) begin miscompares++; $display("FAIL full_drain: got v=%0b count=%0d want 0/0", bus.iss_valid, bus.count); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        set_disp(6'h03, 1'b0, '0, 4'd4, 1'b1, 32'd5, 4'd0, 4'd6);
        set_cdb(0, 4'd4, 32'h11);
        step();
        bus.disp_valid = 1'b0; bus.cdb_valid = '0;
        vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL bypass_early: got %0b want 0", bus.iss_valid); end
        step();
        vectors++;
        if ({bus.iss_valid, bus.iss_r1, bus.iss_r2} !== {1'b1, 32'h11, 32'd5}) begin
            miscompares++; $display("FAIL bypass_capture: got v=%0b r1=%h r2=%0d want 1/11/5", bus.iss_valid, bus.iss_r1, bus.iss_r2);
        end
        step();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_disp(6'h04, 1'b1, DW'(10 + i), 4'd0, 1'b1, 32'd0, 4'd0, TW'(i));
            step();
        end
        bus.disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({bus.iss_valid, bus.iss_r1, bus.count} !== {1'b1, 32'd10, CW'(3)}) begin
                miscompares++; $display("FAIL bp_hold_%0d: got v=%0b r1=%0d count=%0d want 1/10/3", c, bus.iss_valid, bus.iss_r1, bus.count);
            end
        end
        bus.iss_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            vectors++;
            if ({bus.iss_valid, bus.iss_r1} !== {1'b1, DW'(10 + i)}) begin
                miscompares++; $display("FAIL bp_release_%0d: got v=%0b r1=%0d want 1/%0d", i, bus.iss_valid, bus.iss_r1, 10 + i);
            end
        end
        step();
        vectors++; if (bus.iss_valid !== 1'b0 || bus.count !== CW'(0)) begin miscompares++; $display("FAIL bp_drain: got v=%0b count=%0d want 0/0", bus.iss_valid, bus.count); end
    endtask

    task automatic test_multi_match();
        idle_inputs();
        set_disp(6'h05, 1'b0, '0, 4'd6, 1'b0, '0, 4'd6, 4'd1);
        step();
        bus.disp_valid = 1'b0;
        set_cdb(1, 4'd6, 32'h22);
        set_cdb(3, 4'd6, 32'h33);
        step();
        bus.cdb_valid = '0;
        step();
        vectors++;
        if ({bus.iss_valid, bus.iss_r1, bus.iss_r2} !== {1'b1, 32'h22, 32'h22}) begin
            miscompares++; $display("FAIL multi_match: got v=%0b r1=%h r2=%h want 1/22/22", bus.iss_valid, bus.iss_r1, bus.iss_r2);
        end
        step();
    endtask

    task automatic test_freeze();
        idle_inputs();
        set_disp(6'h06, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd2);
        rdy = 1'b0;
        step(); step();
        vectors++; if (bus.count !== CW'(0) || bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL freeze: got count=%0d v=%0b want 0/0", bus.count, bus.iss_valid); end
        rdy = 1'b1;
        step();
        bus.disp_valid = 1'b0;
        vectors++; if (bus.count !== CW'(1)) begin miscompares++; $display("FAIL unfreeze: got %0d want 1", bus.count); end
        step(); step();
    endtask

    task automatic test_clear();
        idle_inputs();
        bus.iss_ready = 1'b0;
        set_disp(6'h07, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            set_disp(6'h07, 1'b0, '0, 4'd2, 1'b1, 32'd0, 4'd0, TW'(i + 1));
            step();
        end
        bus.disp_valid = 1'b0;
        vectors++; if (bus.count !== CW'(5) || bus.iss_valid !== 1'b1) begin miscompares++; $display("FAIL clear_setup: got count=%0d v=%0b want 5/1", bus.count, bus.iss_valid); end
        clear = 1'b1;
        bus.iss_ready = 1'b1;
        set_disp(6'h07, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0, 4'd9);
        set_cdb(0, 4'd2, 32'h55);
        step();
        clear = 1'b0; bus.disp_valid = 1'b0;
        vectors++;
        if ({bus.count, bus.full, bus.iss_valid} !== {CW'(0), 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL clear_state: got count=%0d full=%0b v=%0b want 0/0/0", bus.count, bus.full, bus.iss_valid);
        end
        vectors++; if ({bus.iss_op, bus.iss_r1, bus.iss_dest} !== '0) begin miscompares++; $display("FAIL clear_fields: got %h want 0", {bus.iss_op, bus.iss_r1, bus.iss_dest}); end
        for (int c = 0; c < 3; c++) begin
            step();
            bus.cdb_valid = '0;
            vectors++; if (bus.iss_valid !== 1'b0) begin miscompares++; $display("FAIL clear_no_issue_%0d: got %0b want 0", c, bus.iss_valid); end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            rdy   = ($urandom_range(9) != 0);
            clear = rdy && ($urandom_range(49) == 0);
            bus.iss_ready = ($urandom_range(9) < 7);
            if ($urandom_range(1) == 1) begin
                set_disp(OW'($urandom), 1'($urandom), $urandom, TW'($urandom_range(7)),
                         1'($urandom), $urandom, TW'($urandom_range(7)), TW'($urandom));
            end else begin
                bus.disp_valid = 1'b0;
            end
            for (int k = 0; k < NC; k++) begin
                bus.cdb_valid[k] = ($urandom_range(3) == 0);
                bus.cdb_tag[k*TW +: TW] = TW'($urandom_range(7));
                bus.cdb_data[k*DW +: DW] = $urandom;
            end
            step();
            vectors++;
            if ({bus.iss_valid, bus.count, bus.full} !== {m_iss_valid, CW'(m_count()), m_count() == D}) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc %0d: got v=%0b count=%0d full=%0b want %0b/%0d/%0b",
                         c, bus.iss_valid, bus.count, bus.full, m_iss_valid, m_count(), m_count() == D);
            end
            vectors++;
            if ({bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_imm, bus.iss_pc, bus.iss_dest} !== m_iss_fields) begin
                miscompares++;
                $display("FAIL rand_fields cyc %0d: got %h want %h", c,
                         {bus.iss_op, bus.iss_r1, bus.iss_r2, bus.iss_imm, bus.iss_pc, bus.iss_dest}, m_iss_fields);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_next_seq = 0;
        test_reset();
        test_basic();
        test_full();
        test_bypass();
        test_backpressure();
        test_multi_match();
        test_freeze();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
